// File: rtl/instruction_fetch_unit.sv
// Purpose : fetch stage; owns the 4-bit PC, addresses instruction memory, captures into IR.
// Latency : one edge from PC presentation to IR; redirect costs one bubble cycle.
// Backpr. : IR holds while ir_valid && !dec_ready; the PC holds with it. Fetch resumes on the release edge with no bubble.
//
// Ports:
//   clk, reset (async, active-high)
//   imem_addr / imem_instr          : combinational instruction memory read
//   ir_instr, ir_pc, ir_valid       : instruction register toward decode
//   dec_ready                       : decoder consumes IR when ir_valid is high
//   redirect_valid, redirect_target : taken branch/jump; flushes IR
//   halted                          : high while stopped on HALT_INSTR
module instruction_fetch_unit #(
    parameter logic [7:0] HALT_INSTR = 8'hFF,
    parameter logic [3:0] RESET_PC   = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] imem_addr,
    input  logic [7:0] imem_instr,
    output logic [7:0] ir_instr,
    output logic [3:0] ir_pc,
    output logic       ir_valid,
    input  logic       dec_ready,
    input  logic       redirect_valid,
    input  logic [3:0] redirect_target,
    output logic       halted
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] ir_pc_q, ir_pc_d;
    logic       valid_q, valid_d;
    logic       can_load;

    // IR is free when empty or when its current content is consumed this cycle.
    assign can_load = !valid_q || dec_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            ir_pc_q <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;

        if (redirect_valid) begin
            // Flush wins over consumption and over halt; the word on
            // imem_instr belongs to the wrong path and is dropped.
            pc_d    = redirect_target;
            valid_d = 1'b0;
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (can_load) begin
                        ir_d    = imem_instr;
                        ir_pc_d = pc_q;
                        valid_d = 1'b1;
                        if (imem_instr == HALT_INSTR) begin
                            // Halt is delivered to decode; PC parks on it.
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_q + 4'd1;
                        end
                    end
                end
                HALTED: begin
                    if (valid_q && dec_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign ir_instr  = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = valid_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic       clk;
    logic       reset;
    logic [3:0] imem_addr;
    logic [7:0] imem_instr;
    logic [7:0] ir_instr;
    logic [3:0] ir_pc;
    logic       ir_valid;
    logic       dec_ready;
    logic       redirect_valid;
    logic [3:0] redirect_target;
    logic       halted;

    logic [7:0] mem [16];

    int vectors;
    int miscompares;

    // Reference model state: what decode should see, plus the fetch pointer.
    logic [3:0] m_pc;
    logic [7:0] m_ir;
    logic [3:0] m_irpc;
    logic       m_valid;
    logic       m_halted;

    instruction_fetch_unit #(
        .HALT_INSTR(8'hFF),
        .RESET_PC  (4'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .ir_instr       (ir_instr),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halted         (halted)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bound_expired(input string tag);
        vectors++;
        miscompares++;
        $display("FAIL %s wait bound expired", tag);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".addr"},   {4'd0, imem_addr}, {4'd0, m_pc});
        chk({tag, ".valid"},  {7'd0, ir_valid},  {7'd0, m_valid});
        chk({tag, ".halted"}, {7'd0, halted},    {7'd0, m_halted});
        chk({tag, ".ir"},     ir_instr,          m_ir);
        chk({tag, ".irpc"},   {4'd0, ir_pc},     {4'd0, m_irpc});
    endtask

    task automatic model_reset();
        m_pc     = 4'd0;
        m_ir     = 8'h00;
        m_irpc   = 4'd0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    // One clock: apply inputs, advance the model by the stated rules, check after the edge.
    task automatic step(input logic rdy, input logic rv, input logic [3:0] tgt, input string tag);
        logic [7:0] word;
        dec_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        word = mem[m_pc];
        if (rv) begin
            m_pc     = tgt;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (m_halted) begin
            if (m_valid && rdy) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            m_ir    = word;
            m_irpc  = m_pc;
            m_valid = 1'b1;
            if (word == 8'hFF) m_halted = 1'b1;
            else               m_pc = 4'((int'(m_pc) + 1) % 16);
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        bit done;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        reset           = 1'b1;
        dec_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        reset = 1'b0;
        #1;
        chk_all("reset_rel");

        // Free run across the PC wrap.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 4'd0, "run");
        chk("run_irpc3", {4'd0, ir_pc}, 8'd3);

        // Stall at ir_pc = 3 for three cycles, then release without a bubble.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, "stall");
        chk("stall_ir",   ir_instr, 8'h13);
        chk("stall_addr", {4'd0, imem_addr}, 8'd4);
        step(1'b1, 1'b0, 4'd0, "stall_rel");
        chk("stall_rel_ir", ir_instr, 8'h14);

        // Redirect to 9 while IR holds 8'h12.
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (m_valid && m_ir == 8'h12) done = 1'b1;
            else step(1'b1, 1'b0, 4'd0, "seek12");
        end
        if (!done) bound_expired("seek12");
        step(1'b1, 1'b1, 4'd9, "redir");
        chk("redir_valid", {7'd0, ir_valid}, 8'd0);
        chk("redir_addr",  {4'd0, imem_addr}, 8'd9);
        step(1'b1, 1'b0, 4'd0, "redir_tgt");
        chk("redir_ir", ir_instr, 8'h19);

        // Halt encoding at address 5.
        mem[5] = 8'hFF;
        step(1'b1, 1'b1, 4'd0, "to0");
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (m_halted) done = 1'b1;
            else step(1'b1, 1'b0, 4'd0, "seekhalt");
        end
        if (!done) bound_expired("seekhalt");
        chk("halt_ir",   ir_instr, 8'hFF);
        chk("halt_flag", {7'd0, halted}, 8'd1);
        step(1'b0, 1'b0, 4'd0, "halt_hold");
        step(1'b1, 1'b0, 4'd0, "halt_consume");
        chk("halt_consumed", {7'd0, ir_valid}, 8'd0);
        step(1'b1, 1'b0, 4'd0, "halt_idle");
        chk("halt_addr", {4'd0, imem_addr}, 8'd5);
        mem[5] = 8'h15;
        step(1'b1, 1'b1, 4'd0, "halt_exit");
        step(1'b1, 1'b0, 4'd0, "halt_resume");
        chk("resume_ir", ir_instr, 8'h10);

        // Redirect during a stall flushes the IR.
        step(1'b0, 1'b0, 4'd0, "rs_stall");
        step(1'b0, 1'b1, 4'd2, "rs_redir");
        chk("rs_addr", {4'd0, imem_addr}, 8'd2);

        // Asynchronous reset between edges with PC at 7.
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (m_pc == 4'd7) done = 1'b1;
            else step(1'b1, 1'b0, 4'd0, "seek7");
        end
        if (!done) bound_expired("seek7");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_all("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 4'd0, "post_rst");
        chk("post_rst_irpc", {4'd0, ir_pc}, 8'd0);

        // Random traffic with occasional halts and redirects.
        for (int i = 0; i < 16; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 4'($urandom_range(0, 15)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the 8-bit processor: owns the 4-bit program counter, drives the address into `instruction_memory`, and captures the returned instruction into an instruction register (IR) for the decoder. Provides a valid/ready handshake toward decode, branch/jump redirection with flush, and a halt state on a dedicated halt encoding.

## Interface
- `HALT_INSTR`, default 8'hFF: instruction encoding that stops fetching.
- `RESET_PC`, default 4'd0: PC value after reset.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `imem_addr` output 4: address to `instruction_memory`; always equals the PC register (no logic after the flop).
- `imem_instr` input 8: instruction returned combinationally by `instruction_memory` for `imem_addr`.
- `ir_instr` output 8: captured instruction.
- `ir_pc` output 4: address the captured instruction came from.
- `ir_valid` output 1: IR holds an instruction not yet consumed.
- `dec_ready` input 1: decoder accepts IR this cycle when `ir_valid` is 1.
- `redirect_valid` input 1: branch/jump taken this cycle.
- `redirect_target` input 4: new PC when `redirect_valid` is 1.
- `halted` output 1: unit is in HALTED state.

## Operation
- Reset values: PC = `RESET_PC`, `ir_instr` = 8'h00, `ir_pc` = 4'd0, `ir_valid` = 0, state = FETCH, `halted` = 0.
- States: FETCH, HALTED. `halted` = 1 exactly in HALTED.
- IR "can load" = (`ir_valid` == 0) or (`dec_ready` == 1).
- Priority per edge: reset > redirect > halt/fetch/stall.
- Redirect (any state): PC <= `redirect_target`; `ir_valid` <= 0 (IR content discarded even if `dec_ready`); state <= FETCH. Instruction on `imem_instr` that cycle is not captured.
- FETCH, can load, `imem_instr` != `HALT_INSTR`: IR <= `imem_instr`, `ir_pc` <= PC, `ir_valid` <= 1, PC <= PC + 1 modulo 16 (4'd15 wraps to 4'd0).
- FETCH, can load, `imem_instr` == `HALT_INSTR`: IR <= `HALT_INSTR`, `ir_pc` <= PC, `ir_valid` <= 1, PC holds, state <= HALTED. The halt instruction is delivered to decode.
- FETCH, cannot load (`ir_valid` = 1, `dec_ready` = 0): stall; PC, IR, `ir_pc`, `ir_valid` hold.
- HALTED: no capture, PC holds. If `ir_valid` and `dec_ready`: `ir_valid` <= 0. Exit only via redirect or reset.
- `dec_ready` while `ir_valid` = 0 has no effect beyond permitting a load.

## Timing
- `imem_addr` changes only on clock edges or asynchronously at reset assertion.
- Fetch latency: instruction at PC appears in IR one edge after PC is presented; first instruction valid after first rising edge following reset release.
- Sustained throughput with `dec_ready` = 1: one instruction per cycle, `ir_valid` continuously 1.
- Redirect penalty: one bubble; `ir_valid` = 0 for the cycle after redirect edge, target instruction valid the edge after.
- Stall release: the edge on which `dec_ready` = 1 both consumes the old IR and loads the next instruction (no bubble).
- Reset asserted mid-operation: outputs take reset values without waiting for a clock edge; first fetch after release restarts at `RESET_PC`.

## Test plan
- Reset then free run, memory model addr n -> 8'h10+n, `dec_ready` = 1: IR shows 8'h10, 8'h11, 8'h12... with `ir_pc` 0,1,2...; after `ir_pc` = 15 next is `ir_pc` = 0 (wrap).
- Stall: at `ir_pc` = 3 hold `dec_ready` = 0 for 3 cycles -> IR stays 8'h13, `imem_addr` stays 4; releasing gives 8'h14 on the next edge with no bubble.
- Redirect: `redirect_valid` = 1, target 4'd9 while IR holds 8'h12 -> next cycle `ir_valid` = 0, `imem_addr` = 9; following cycle IR = 8'h19, `ir_pc` = 9.
- Halt: place 8'hFF at addr 5 -> IR = 8'hFF, `ir_pc` = 5, `halted` = 1, `imem_addr` stays 5; after consumption `ir_valid` = 0; redirect to 4'd0 resumes with 8'h10 and `halted` = 0.
- Redirect and stall together: `ir_valid` = 1, `dec_ready` = 0, `redirect_valid` = 1 target 4'd2 -> IR flushed (`ir_valid` = 0), PC = 2.
- Asynchronous reset mid-run at PC = 7 between clock edges: `imem_addr` = 0, `ir_valid` = 0, `halted` = 0 immediately; first post-release capture is addr 0.
